// File: rtl/rom_port_arbiter_if.sv
// Bundle of the two requester handshakes, the ROM bus and the busy flag.
// The arbiter uses the slave view; requesters and the ROM sit on the master view.
interface rom_port_arbiter_if #(
  parameter int IDX_W  = 8,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [IDX_W-1:0]  if_index;
  logic              if_ack;
  logic [DATA_W-1:0] if_data;
  logic              dm_req;
  logic [IDX_W-1:0]  dm_index;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_data;
  logic [31:0]       rom_address;
  logic [DATA_W-1:0] rom_data;
  logic              busy;

  modport slave (
    input  if_req, if_index, dm_req, dm_index, rom_data,
    output if_ack, if_data, dm_ack, dm_data, rom_address, busy
  );

  modport master (
    output if_req, if_index, dm_req, dm_index, rom_data,
    input  if_ack, if_data, dm_ack, dm_data, rom_address, busy
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter between instruction fetch and data read for the shared ROM.
// Sequences one access at a time: IDLE -> ACCESS (WAIT_CYCLES) -> RESP (ack) -> IDLE.
module rom_port_arbiter #(
  parameter int IDX_W       = 8,   // must be <= 8; the ROM decodes only 8 index bits
  parameter int DATA_W      = 64,
  parameter int WAIT_CYCLES = 1    // 1..15
) (
  input  logic              clock,
  input  logic              reset,
  rom_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [31:0] PARK_ADDR = 32'h0000_0000;
  localparam logic [3:0]  LAST_CNT  = 4'(WAIT_CYCLES - 1);

  state_t            state, state_n;
  owner_t            owner, last_grant;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] if_data_q, dm_data_q;
  logic              grant_if, grant_dm, capture;
  logic [7:0]        idx8;

  assign idx8 = 8'(idx_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_n         = state;
    grant_if        = 1'b0;
    grant_dm        = 1'b0;
    capture         = 1'b0;
    bus.rom_address = PARK_ADDR;
    case (state)
      IDLE: begin
        // On a tie the side that was not granted last time wins.
        if (bus.if_req && (!bus.dm_req || last_grant == OWN_DM)) begin
          grant_if = 1'b1;
          state_n  = ACCESS;
        end else if (bus.dm_req) begin
          grant_dm = 1'b1;
          state_n  = ACCESS;
        end
      end
      ACCESS: begin
        bus.rom_address = {12'h000, idx8, 12'hFFF};
        if (cnt == LAST_CNT) begin
          capture = 1'b1;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner      <= OWN_IF;
      last_grant <= OWN_DM;
      idx_q      <= '0;
      cnt        <= '0;
      if_data_q  <= '0;
      dm_data_q  <= '0;
    end else begin
      if (grant_if || grant_dm) begin
        owner      <= grant_dm ? OWN_DM : OWN_IF;
        last_grant <= grant_dm ? OWN_DM : OWN_IF;
        idx_q      <= grant_dm ? bus.dm_index : bus.if_index;
        cnt        <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 4'd1;
      end
      if (capture) begin
        if (owner == OWN_IF) if_data_q <= bus.rom_data;
        else                 dm_data_q <= bus.rom_data;
      end
    end
  end

  assign bus.if_ack  = (state == RESP) && (owner == OWN_IF);
  assign bus.dm_ack  = (state == RESP) && (owner == OWN_DM);
  assign bus.if_data = if_data_q;
  assign bus.dm_data = dm_data_q;
  assign bus.busy    = (state != IDLE);

endmodule
